// File: rtl/i4001_pkg.sv
// i4001_pkg -- shared types and constants for the i4001_bank ROM/port emulator.
//   phase_e     : MCS-4 instruction-cycle phase (IDLE before the first sync)
//   OPA_WRR/RDR : I/O opcodes decoded after an SRC has selected a chip
//   chip_offset : chip number relative to the bank's base chip (mod 16)
package i4001_pkg;

  typedef enum logic [3:0] {
    IDLE, A1, A2, A3, M1, M2, X1, X2, X3
  } phase_e;

  localparam logic [3:0] OPA_WRR = 4'b0010;
  localparam logic [3:0] OPA_RDR = 4'b1010;

  function automatic logic [3:0] chip_offset(input logic [3:0] num, input logic [3:0] base);
    return num - base;
  endfunction

endpackage

// File: rtl/i4001_bank_if.sv
// i4001_bank_if -- MCS-4 bus as seen by a 4001 bank.
//   clk1, clk2 : two-phase bus clocks (sampled on sysclk)
//   sync       : instruction-cycle marker
//   cmrom      : ROM command line
//   data_in    : 4-bit bus value driven by the CPU side
//   data_out   : 4-bit value driven by the bank
//   data_oe    : bank bus drive enable
// master = CPU / bus side, slave = the bank.
interface i4001_bank_if;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic       cmrom;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_oe;

  modport master (output clk1, clk2, sync, cmrom, data_in, input data_out, data_oe);
  modport slave  (input clk1, clk2, sync, cmrom, data_in, output data_out, data_oe);
endinterface

// File: rtl/i4001_phase_seq.sv
// i4001_phase_seq -- clk2 falling-edge detector and instruction-phase FSM.
//   sysclk, poc_n : system clock, async active-low reset
//   clk2, sync    : bus inputs (sampled on sysclk)
//   phase         : current phase (IDLE until the first sync)
//   c2_fall       : high for the sysclk in which a clk2 fall is seen;
//                   the phase advances on the sysclk edge closing that cycle
module i4001_phase_seq
  import i4001_pkg::*;
(
  input  logic   sysclk,
  input  logic   poc_n,
  input  logic   clk2,
  input  logic   sync,
  output phase_e phase,
  output logic   c2_fall
);

  phase_e phase_q, phase_d;
  logic   clk2_q, clk2_d;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      phase_q <= IDLE;
      clk2_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      clk2_q  <= clk2_d;
    end
  end

  always_comb begin
    clk2_d  = clk2;
    phase_d = phase_q;
    if (c2_fall) begin
      if (sync) begin
        phase_d = A1;
      end else begin
        case (phase_q)
          A1:      phase_d = A2;
          A2:      phase_d = A3;
          A3:      phase_d = M1;
          M1:      phase_d = M2;
          M2:      phase_d = X1;
          X1:      phase_d = X2;
          X2:      phase_d = X3;
          X3:      phase_d = A1;
          default: phase_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    c2_fall = clk2_q & ~clk2;
    phase   = phase_q;
  end

endmodule

// File: rtl/i4001_bank.sv
// i4001_bank -- bank of NUM_CHIPS emulated 4001 ROM + I/O port chips.
//   sysclk, poc_n : system clock, async active-low reset
//   bus           : MCS-4 bus (slave side)
//   rom_addr      : {chip number, 8-bit address} to shared block RAM
//   rom_data      : block RAM data, one sysclk after rom_addr
//   io_in/io_out  : port pins, 4 per chip; io_oe mirrors IO_OUTPUT
//   clear         : synchronous clear of all output latches
//   io_wr_strobe  : one-sysclk pulse per chip on each port write
// Optional: define I4001_BANK_IO_SYNC_EN to pass io_in through a 2-flop
// synchronizer before it is read back by RDR.
module i4001_bank
  import i4001_pkg::*;
#(
  parameter int unsigned              NUM_CHIPS = 2,
  parameter logic [3:0]               BASE_CHIP = 4'd0,
  parameter logic [4*NUM_CHIPS-1:0]   IO_OUTPUT = '0,
  parameter logic [4*NUM_CHIPS-1:0]   IO_INVERT = '0
) (
  input  logic                   sysclk,
  input  logic                   poc_n,
  i4001_bank_if.slave            bus,
  output logic [11:0]            rom_addr,
  input  logic [7:0]             rom_data,
  input  logic [4*NUM_CHIPS-1:0] io_in,
  output logic [4*NUM_CHIPS-1:0] io_out,
  output logic [4*NUM_CHIPS-1:0] io_oe,
  input  logic                   clear,
  output logic [NUM_CHIPS-1:0]   io_wr_strobe
);

  localparam int unsigned W = 4 * NUM_CHIPS;

  phase_e phase;
  logic   c2_fall;

  i4001_phase_seq u_seq (
    .sysclk  (sysclk),
    .poc_n   (poc_n),
    .clk2    (bus.clk2),
    .sync    (bus.sync),
    .phase   (phase),
    .c2_fall (c2_fall)
  );

  // clk1 carries no information needed once clk2 edges are tracked.
  logic unused_clk1;
  always_comb unused_clk1 = bus.clk1;

  logic [7:0]           addr_q, addr_d;
  logic [11:0]          rom_addr_q, rom_addr_d;
  logic                 romsel_q, romsel_d;
  logic                 srcsel_q, srcsel_d;
  logic [3:0]           srcidx_q, srcidx_d;
  logic                 wrr_pend_q, wrr_pend_d;
  logic                 rdr_pend_q, rdr_pend_d;
  logic [W-1:0]         latch_q, latch_d;
  logic [NUM_CHIPS-1:0] strobe_q, strobe_d;

  logic [3:0]   chip_off;
  logic         chip_hit;
  logic [W-1:0] pins;
  logic [W-1:0] port_word;
  logic [3:0]   rd_nib;

`ifdef I4001_BANK_IO_SYNC_EN
  logic [W-1:0] io_s1_q, io_s2_q;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      io_s1_q <= '0;
      io_s2_q <= '0;
    end else begin
      io_s1_q <= io_in;
      io_s2_q <= io_s1_q;
    end
  end

  always_comb pins = io_s2_q;
`else
  always_comb pins = io_in;
`endif

  // Offset wraps mod 16, so numbers below BASE_CHIP land high and miss.
  always_comb begin
    chip_off = chip_offset(bus.data_in, BASE_CHIP);
    chip_hit = ({1'b0, chip_off} < 5'(NUM_CHIPS));
  end

  always_comb begin
    port_word = (latch_q & IO_OUTPUT) | ((pins ^ IO_INVERT) & ~IO_OUTPUT);
    rd_nib    = '0;
    for (int unsigned c = 0; c < NUM_CHIPS; c++) begin
      if (srcidx_q == 4'(c)) rd_nib = port_word[4*c +: 4];
    end
  end

  always_comb begin
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    romsel_d   = romsel_q;
    srcsel_d   = srcsel_q;
    srcidx_d   = srcidx_q;
    wrr_pend_d = wrr_pend_q;
    rdr_pend_d = rdr_pend_q;
    latch_d    = latch_q;
    strobe_d   = '0;
    // Every action fires on the clk2 fall that closes the current phase.
    if (c2_fall) begin
      case (phase)
        A1: begin
          addr_d[3:0] = bus.data_in;
          wrr_pend_d  = 1'b0;
          rdr_pend_d  = 1'b0;
        end
        A2: addr_d[7:4] = bus.data_in;
        A3: begin
          romsel_d   = bus.cmrom & chip_hit;
          rom_addr_d = {bus.data_in, addr_q};
        end
        M2: begin
          if (srcsel_q && bus.cmrom) begin
            wrr_pend_d = (bus.data_in == OPA_WRR);
            rdr_pend_d = (bus.data_in == OPA_RDR);
          end
        end
        X2: begin
          // Write uses the chip selected before any SRC on this same edge.
          if (wrr_pend_q) begin
            for (int unsigned c = 0; c < NUM_CHIPS; c++) begin
              if (srcidx_q == 4'(c)) begin
                latch_d[4*c +: 4] = bus.data_in;
                strobe_d[c]       = 1'b1;
              end
            end
          end
          if (bus.cmrom) begin
            srcsel_d = chip_hit;
            srcidx_d = chip_off;
          end
        end
        default: ;
      endcase
    end
    if (clear) begin
      latch_d  = '0;
      strobe_d = '0;
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      addr_q     <= '0;
      rom_addr_q <= '0;
      romsel_q   <= 1'b0;
      srcsel_q   <= 1'b0;
      srcidx_q   <= '0;
      wrr_pend_q <= 1'b0;
      rdr_pend_q <= 1'b0;
      latch_q    <= '0;
      strobe_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      romsel_q   <= romsel_d;
      srcsel_q   <= srcsel_d;
      srcidx_q   <= srcidx_d;
      wrr_pend_q <= wrr_pend_d;
      rdr_pend_q <= rdr_pend_d;
      latch_q    <= latch_d;
      strobe_q   <= strobe_d;
    end
  end

  // Drive follows the phase register, so reset (phase -> IDLE) drops it at once.
  always_comb begin
    bus.data_out = '0;
    bus.data_oe  = 1'b0;
    case (phase)
      M1: begin
        bus.data_out = rom_data[7:4];
        bus.data_oe  = romsel_q;
      end
      M2: begin
        bus.data_out = rom_data[3:0];
        bus.data_oe  = romsel_q;
      end
      X1: begin
        if (rdr_pend_q) begin
          bus.data_out = rd_nib;
          bus.data_oe  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rom_addr     = rom_addr_q;
    io_out       = (latch_q ^ IO_INVERT) & IO_OUTPUT;
    io_oe        = IO_OUTPUT;
    io_wr_strobe = strobe_q;
  end

endmodule
